i2c_eeprom_slave: RTL and testbench
===================================

Name: i2c_eeprom_slave

Overview:
- Synthesizable I2C responder emulating a 24AA02-style serial EEPROM: 7-bit device address, 8-bit word address, internal 2^ADDR_WIDTH x 8 RAM.
- Target end of the i2c_eeprom_test master. Used on-chip for loopback tests and in benches in place of the behavioural memory model.
- Open-drain: the block only ever pulls SDA low; the top level ties sda_oe to a tristate with a pull-up.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address matched after START.
- ADDR_WIDTH, 8, word address and RAM depth (256 bytes).
- PAGE_SIZE, 8, write page size; power of two, at most 2^ADDR_WIDTH.
- FILTER_LEN, 3, sys_clk cycles a synchronized SCL/SDA level must stay stable before it is accepted.

Ports:
- sys_clk  in  1  system clock, 50 MHz nominal.
- rst  in  1  synchronous reset, active-high.
- scl_i  in  1  SCL pin level, asynchronous.
- sda_i  in  1  SDA pin level, asynchronous.
- sda_oe  out  1  1 = drive SDA low, 0 = release SDA.
- wr_valid  out  1  one-cycle pulse when a data byte is committed to RAM.
- wr_addr  out  ADDR_WIDTH  RAM address of the committed byte.
- wr_data  out  8  committed byte.
- busy  out  1  high from an accepted address match until STOP, or until a NACK/mismatch returns the block to IDLE.

Behaviour:
- Reset: sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, word pointer=0. RAM contents are not cleared. Reset mid-transfer releases SDA in the next cycle.
- Input path: each of scl_i and sda_i passes through a 2-flop synchronizer, then a FILTER_LEN stability filter. Edges are detected on the filtered levels (scl_f, sda_f).
- START: sda_f falls while scl_f is high. Valid in any state, including repeated START. Enters DEV_ADDR and clears the bit counter.
- STOP: sda_f rises while scl_f is high. From any state, goes to IDLE, releases SDA and clears busy.
- Sampling and driving: bits are sampled on the scl_f rising edge. sda_oe changes only on the cycle after a scl_f falling edge. Worst-case SCL pin fall to sda_oe update is FILTER_LEN+4 cycles.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits, MSB first.
  - DEV_ACK: on address match, drive ACK for one SCL period; next state is WORD_ADDR if R/W=0, RD_DATA if R/W=1. On mismatch, release SDA and return to IDLE.
  - WORD_ADDR: shift 8 bits.
  - WORD_ACK: ACK; load the word pointer from the low ADDR_WIDTH bits; go to WR_DATA.
  - WR_DATA: shift 8 bits.
  - WR_ACK: ACK; commit the byte (wr_valid pulses on the cycle of the 8th SCL rise); increment the pointer within the page only (upper bits held, low log2(PAGE_SIZE) bits wrap).
  - RD_DATA: drive RAM[pointer] MSB first; sda_oe = ~bit.
  - RD_ACK: release SDA and sample the master's bit. 0 (ACK): pointer+1 with full-array wrap (0xFF -> 0x00), then RD_DATA. 1 (NACK): IDLE.
- Current-address read (START + DEV_ADDR/R with no word address) uses the existing pointer.
- A STOP or START arriving mid-byte discards the partial byte; nothing is written.
- RAM read is registered. The byte is fetched during the ACK phase, so it is ready before the first data bit is driven.

Optional Feature:
- Macro WRITE_PROTECT_EN.
- When defined: adds input port wp (1 bit). While wp=1, data bytes are still ACKed but neither written nor signalled: wr_valid stays 0. The pointer still advances.
- When undefined: no wp port; writes are always enabled.

Test Plan:
- Byte write: START, 0xA0, 0x12, 0x5A, STOP -> ACK on all three bytes; one wr_valid with wr_addr=0x12, wr_data=0x5A; busy low after STOP.
- Page wrap: write 0xA0, 0x06, then 0x01..0x04 -> RAM[0x06]=0x01, [0x07]=0x02, [0x00]=0x03, [0x01]=0x04.
- Random read: START, 0xA0, 0x12, repeated START, 0xA1 -> SDA returns 0x5A; master NACK -> sda_oe=0, state IDLE.
- Sequential read wrap: pointer set to 0xFE, read 3 bytes with ACK, ACK, NACK -> RAM[0xFE], [0xFF], [0x00] returned in order.
- Address mismatch: START, 0xA2 -> no ACK (SDA stays high during the 9th clock); no wr_valid; busy stays 0.
- Abort/reset: STOP after 4 data bits, then assert rst mid-read -> no write occurs; sda_oe=0 on the cycle after rst.

Source files
------------

// File: rtl/i2c_eeprom_slave.sv
//------------------------------------------------------------------------------
// i2c_eeprom_slave
// I2C responder emulating a 24AA02-style serial EEPROM: 7-bit device address,
// 8-bit word address, internal 2^ADDR_WIDTH x 8 RAM. Open-drain: the block
// only ever pulls SDA low through sda_oe.
//
// Optional feature macro: WRITE_PROTECT_EN
//   defined   -> adds input wp; while wp=1 data bytes are ACKed, the pointer
//                advances, but nothing is written and wr_valid stays 0.
//   undefined -> no wp port, writes always enabled.
//
// Ports:
//   sys_clk   system clock (50 MHz nominal)
//   rst       synchronous reset, active-high
//   scl_i     SCL pin level (asynchronous)
//   sda_i     SDA pin level (asynchronous)
//   wp        write protect (only with WRITE_PROTECT_EN)
//   sda_oe    1 = pull SDA low, 0 = release
//   wr_valid  one-cycle pulse when a data byte is committed to RAM
//   wr_addr   RAM address of the committed byte
//   wr_data   committed byte
//   busy      high from an accepted address match until STOP / NACK / mismatch
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module i2c_eeprom_slave #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         ADDR_WIDTH = 8,
    parameter int         PAGE_SIZE  = 8,
    parameter int         FILTER_LEN = 3
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
`ifdef WRITE_PROTECT_EN
    input  logic                  wp,
`endif
    output logic                  sda_oe,
    output logic                  wr_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    localparam int                    FCW       = $clog2(FILTER_LEN + 1);
    localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ADDR_WIDTH'(PAGE_SIZE - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_WORD_ADDR,
        ST_WORD_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK
    } state_t;

    // ---------------------------------------------------------------------
    // Input path: 2-flop synchronizer + stability filter. Index 1 = SCL,
    // index 0 = SDA. The bus idles high, so everything resets to 1.
    // ---------------------------------------------------------------------
    logic [1:0]     pins, sync1, sync2, filt, filt_d;
    logic [FCW-1:0] fcnt [2];

    assign pins = {scl_i, sda_i};

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1   <= '1;
            sync2   <= '1;
            filt    <= '1;
            filt_d  <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= pins;
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    assign scl_f     = filt[1];
    assign sda_f     = filt[0];
    assign scl_rise  =  scl_f & ~filt_d[1];
    assign scl_fall  = ~scl_f &  filt_d[1];
    assign start_det =  scl_f &  filt_d[1] &  filt_d[0] & ~sda_f;
    assign stop_det  =  scl_f &  filt_d[1] & ~filt_d[0] &  sda_f;

    // ---------------------------------------------------------------------
    // Protocol state
    // ---------------------------------------------------------------------
    state_t                state, state_next;
    logic [2:0]            bit_cnt;       // wraps 7 -> 0 at the 8th rise
    logic [6:0]            shift_reg;
    logic [ADDR_WIDTH-1:0] ptr, ptr_page_inc;
    logic [7:0]            rd_byte, rx_byte;
    logic                  last_bit, wr_en;
    logic                  do_count, do_shift, do_load_ptr, do_commit, do_rd_inc;
    logic                  set_busy, clr_busy, oe_next;

    assign rx_byte      = {shift_reg, sda_f};
    assign last_bit     = (bit_cnt == 3'd7);
    // Page write: upper pointer bits hold, the in-page offset wraps.
    assign ptr_page_inc = (ptr & ~PAGE_MASK) | ((ptr + 1'b1) & PAGE_MASK);

`ifdef WRITE_PROTECT_EN
    assign wr_en = ~wp;
`else
    assign wr_en = 1'b1;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        oe_next     = sda_oe;
        do_count    = 1'b0;
        do_shift    = 1'b0;
        do_load_ptr = 1'b0;
        do_commit   = 1'b0;
        do_rd_inc   = 1'b0;
        set_busy    = 1'b0;
        clr_busy    = 1'b0;

        if (stop_det) begin
            state_next = ST_IDLE;
            oe_next    = 1'b0;
            clr_busy   = 1'b1;
        end else if (start_det) begin
            state_next = ST_DEV_ADDR;
            oe_next    = 1'b0;
        end else if (scl_fall) begin
            // SDA only changes while SCL is low.
            case (state)
                ST_DEV_ACK, ST_WORD_ACK, ST_WR_ACK: oe_next = 1'b1;
                ST_RD_DATA:                         oe_next = ~rd_byte[3'd7 - bit_cnt];
                default:                            oe_next = 1'b0;
            endcase
        end else if (scl_rise) begin
            case (state)
                ST_DEV_ADDR: begin
                    do_count = 1'b1;
                    do_shift = 1'b1;
                    if (last_bit) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            state_next = ST_DEV_ACK;
                            set_busy   = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                            clr_busy   = 1'b1;
                        end
                    end
                end
                // shift_reg[0] holds the R/W bit during the ACK clock.
                ST_DEV_ACK:  state_next = shift_reg[0] ? ST_RD_DATA : ST_WORD_ADDR;
                ST_WORD_ADDR: begin
                    do_count = 1'b1;
                    do_shift = 1'b1;
                    if (last_bit) begin
                        state_next  = ST_WORD_ACK;
                        do_load_ptr = 1'b1;
                    end
                end
                ST_WORD_ACK: state_next = ST_WR_DATA;
                ST_WR_DATA: begin
                    do_count = 1'b1;
                    do_shift = 1'b1;
                    if (last_bit) begin
                        state_next = ST_WR_ACK;
                        do_commit  = 1'b1;
                    end
                end
                ST_WR_ACK:   state_next = ST_WR_DATA;
                ST_RD_DATA: begin
                    do_count = 1'b1;
                    if (last_bit) state_next = ST_RD_ACK;
                end
                ST_RD_ACK: begin
                    if (!sda_f) begin
                        state_next = ST_RD_DATA;
                        do_rd_inc  = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        clr_busy   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state    <= state_next;
            sda_oe   <= oe_next;
            wr_valid <= 1'b0;

            if (start_det || stop_det) bit_cnt <= '0;
            else if (do_count)         bit_cnt <= bit_cnt + 1'b1;

            if (do_shift) shift_reg <= rx_byte[6:0];

            if (do_load_ptr)    ptr <= ADDR_WIDTH'(rx_byte);
            else if (do_commit) ptr <= ptr_page_inc;
            else if (do_rd_inc) ptr <= ptr + 1'b1;

            if (do_commit && wr_en) begin
                wr_valid <= 1'b1;
                wr_addr  <= ptr;
                wr_data  <= rx_byte;
            end

            if (set_busy)      busy <= 1'b1;
            else if (clr_busy) busy <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // RAM with registered read. rd_byte follows ram[ptr] continuously, so it
    // is settled long before the first bit of a read byte is driven.
    // ---------------------------------------------------------------------
    logic [7:0] ram [2**ADDR_WIDTH];

    // NOTE: the memory is deliberately not reset; its contents survive rst
    // and a reset branch would prevent mapping onto RAM macros.
    always_ff @(posedge sys_clk) begin
        if (do_commit && wr_en) ram[ptr] <= rx_byte;
        rd_byte <= ram[ptr];
    end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
`timescale 1ns/1ps

module tb_i2c_eeprom_slave;

    localparam int         Q         = 8;      // sys_clk cycles per SCL quarter
    localparam logic [7:0] PAGE_MASK = 8'h07;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_pin;
    logic       sda_oe, wr_valid, busy;
    logic [7:0] wr_addr, wr_data;
`ifdef WRITE_PROTECT_EN
    logic       wp = 1'b0;
`endif

    // Open-drain bus: either side can pull low.
    assign sda_pin = sda_m & ~sda_oe;

    always #10 clk = ~clk;

    i2c_eeprom_slave dut (
        .sys_clk  (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_pin),
`ifdef WRITE_PROTECT_EN
        .wp       (wp),
`endif
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    // Reference model: byte array, validity flags, word pointer.
    logic [7:0]  mem_m [256];
    bit          known [256];
    logic [7:0]  ptr_m = 8'h00;
    logic [7:0]  wdata [$];
    logic [15:0] wr_q  [$];
    logic [15:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    always @(negedge clk) begin
        if (wr_valid) wr_q.push_back({wr_addr, wr_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic start_c();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic stop_c();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic clock_bit(input logic out_bit, output logic in_bit);
        sda_m = out_bit; wait_q();
        scl_m = 1'b1;    wait_q();
        in_bit = sda_pin; wait_q();
        scl_m = 1'b0;    wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic dummy, ack_bit;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
        clock_bit(1'b1, ack_bit);
        acked = ~ack_bit;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
        clock_bit(nack, dummy);
    endtask

    task automatic compare_writes();
        check("wr_count", wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check("wr_addr_data", wr_q[i], exp_q[i]);
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic write_txn(input logic [7:0] addr);
        logic       ack;
        logic [7:0] p;
        start_c();
        send_byte(8'hA0, ack); check("wr_dev_ack", ack, 1);
        check("busy_after_match", busy, 1);
        send_byte(addr, ack);  check("wr_word_ack", ack, 1);
        p = addr;
        foreach (wdata[i]) begin
            send_byte(wdata[i], ack); check("wr_data_ack", ack, 1);
            mem_m[p] = wdata[i];
            known[p] = 1'b1;
            exp_q.push_back({p, wdata[i]});
            p = (p & ~PAGE_MASK) | ((p + 8'd1) & PAGE_MASK);
        end
        stop_c();
        ptr_m = p;
        check("busy_after_stop", busy, 0);
        compare_writes();
    endtask

    // set_addr=1: random read (dummy write of the word address first);
    // set_addr=0: current-address read from the model pointer.
    task automatic read_txn(input bit set_addr, input logic [7:0] addr, input int n);
        logic       ack;
        logic [7:0] d, p;
        p = ptr_m;
        if (set_addr) begin
            start_c();
            send_byte(8'hA0, ack); check("rd_dev_ack_w", ack, 1);
            send_byte(addr, ack);  check("rd_word_ack", ack, 1);
            p = addr;
        end
        start_c();
        send_byte(8'hA1, ack); check("rd_dev_ack_r", ack, 1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, d);
            if (known[p]) check("rd_data", d, mem_m[p]);
            if (i != n - 1) p = p + 8'd1;
        end
        check("oe_after_nack", sda_oe, 0);
        check("busy_after_nack", busy, 0);
        stop_c();
        ptr_m = p;
        compare_writes();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack, dummy;
        logic [7:0] a;
        int         n;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sda_oe",   sda_oe,   0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr",  wr_addr,  0);
        check("rst_wr_data",  wr_data,  0);
        check("rst_busy",     busy,     0);
        wait_q();

        // Byte write, then random read back.
        wdata = '{8'h5A};
        write_txn(8'h12);
        read_txn(1'b1, 8'h12, 1);

        // Page wrap inside an 8-byte page.
        wdata = '{8'h01, 8'h02, 8'h03, 8'h04};
        write_txn(8'h06);
        check("page_ptr_model", ptr_m, 8'h02);
        read_txn(1'b1, 8'h06, 2);
        read_txn(1'b1, 8'h00, 2);

        // Sequential read across the top of the array.
        wdata = '{8'hC1, 8'hC2};
        write_txn(8'hFE);
        read_txn(1'b1, 8'hFE, 3);
        read_txn(1'b0, 8'h00, 1);

        // Address mismatch: no ACK, no busy, no write.
        start_c();
        send_byte(8'hA2, ack);
        check("mismatch_ack", ack, 0);
        check("mismatch_busy", busy, 0);
        stop_c();
        compare_writes();
        read_txn(1'b0, 8'h00, 1);

        // Randomized traffic.
        for (int t = 0; t < 12; t++) begin
            a = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: begin
                    n = $urandom_range(1, 9);
                    wdata.delete();
                    for (int i = 0; i < n; i++) wdata.push_back(8'($urandom));
                    write_txn(a);
                end
                1: read_txn(1'b1, a, $urandom_range(1, 4));
                default: read_txn(1'b0, 8'h00, $urandom_range(1, 3));
            endcase
        end

        // STOP after 4 data bits: partial byte discarded.
        wdata = '{8'h11};
        write_txn(8'h30);
        start_c();
        send_byte(8'hA0, ack);
        send_byte(8'h30, ack);
        for (int i = 0; i < 4; i++) clock_bit(1'b0, dummy);
        stop_c();
        ptr_m = 8'h30;
        compare_writes();
        read_txn(1'b0, 8'h00, 1);

        // Reset in the middle of a read while a 0 bit is being driven.
        wdata = '{8'h00};
        write_txn(8'h40);
        start_c();
        send_byte(8'hA0, ack);
        send_byte(8'h40, ack);
        start_c();
        send_byte(8'hA1, ack);
        check("rd_before_rst_ack", ack, 1);
        check("oe_drives_zero", sda_oe, 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("oe_after_rst", sda_oe, 0);
        check("busy_after_rst", busy, 0);
        @(negedge clk) rst = 1'b0;
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        ptr_m = 8'h00;
        compare_writes();
        read_txn(1'b0, 8'h00, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
